i2c_cmd_arbiter: RTL and testbench
==================================

// Module: i2c_cmd_arbiter
// PURPOSE
//  Shares the single I2C_Controller between several command sources: boot-time
//  codec/video config sequencers and runtime volume or input-select writers.
//  Grants round-robin, drives the controller GO/DATA handshake and retries on NACK.
//  Returns a per-requester done/fail pulse. Sits between requesters and the
//  I2C_Controller on the iCLK (50 MHz) domain.
// PARAMETERS
//  NUM_REQ      3      number of requesters (2..8)
//  MAX_RETRY    3      re-launches after NACK before the command is failed
//  TIMEOUT_CYC  65535  iCLK cycles in WAIT_END before abort (16-bit counter)
// PORTS
//  iCLK        in   1            system clock
//  iRST_N      in   1            asynchronous reset, active-low
//  iREQ        in   NUM_REQ      per-requester request level
//  iREQ_DATA   in   24*NUM_REQ   {slave_addr,sub_addr,data}; slice i = [24i+23:24i]
//  oGRANT      out  NUM_REQ      one-hot, owner of the current transaction
//  oDONE       out  NUM_REQ      1-cycle pulse to owner at completion
//  oFAIL       out  1            1-cycle pulse with oDONE on NACK-exhaust or timeout
//  oBUSY       out  1            high in every state except IDLE
//  oI2C_DATA   out  24           to controller I2C_DATA
//  oI2C_GO     out  1            to controller GO
//  iI2C_END    in   1            from controller END (slow clock; 2-flop synced here)
//  iI2C_ACK    in   1            from controller ACK (1 = NACK; 2-flop synced here)
// BEHAVIOUR
//  Reset (async): all outputs 0; rr_ptr=0; retry_cnt=0; tmo_cnt=0; syncs=0; state=IDLE.
//  Assert mid-transaction: oI2C_GO drops at once; no oDONE is issued.
//  States: IDLE -> LAUNCH -> WAIT_END -> (RETRY | FINISH) -> DRAIN -> IDLE.
//  IDLE: if |iREQ, pick first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ);
//    register oGRANT, owner idx and oI2C_DATA from that slice; retry_cnt=0 -> LAUNCH.
//  LAUNCH: oI2C_GO<=1, tmo_cnt<=0 -> WAIT_END.
//  WAIT_END: tmo_cnt++ per cycle. On end_s=1: oI2C_GO<=0.
//    ack_s=0 -> FINISH (ok).
//    ack_s=1 and retry_cnt<MAX_RETRY -> retry_cnt++, RETRY.
//    Otherwise -> FINISH (fail).
//    tmo_cnt==TIMEOUT_CYC with no end_s -> oI2C_GO<=0, FINISH (fail).
//  RETRY: wait end_s=0, then LAUNCH; oI2C_DATA unchanged.
//  FINISH: oDONE[idx]=1 and oFAIL=fail for exactly 1 cycle; oGRANT<=0;
//    rr_ptr<=(idx+1)%NUM_REQ -> DRAIN.
//  DRAIN: wait end_s=0 -> IDLE. The controller never sees GO re-rise while END is high.
//  Latency: iREQ sampled in IDLE at edge N; oGRANT/oI2C_DATA valid at N+1; oI2C_GO at N+2.
//  iREQ_DATA is sampled only at grant. Dropping iREQ while granted does not abort.
//  A requester holds iREQ until its oDONE; a new iREQ rising after oDONE is a new command.
//  The owner re-requesting during FINISH loses to other pending requesters (rr_ptr advanced).
//  oI2C_DATA holds its last value after completion; it is valid only while oGRANT != 0.
//  The sub-addr byte is passed through with no width or arithmetic changes.
// TESTING
//  1. Single req0, data 24'h34_1201, controller model ACKs: oI2C_DATA=341201;
//     GO rises 2 cycles after iREQ; oDONE=001, oFAIL=0, rr_ptr=1.
//  2. iREQ=111 held: grant order 001,010,100,001. No GO overlap; GO low until END low.
//  3. Controller NACKs always, MAX_RETRY=3: 4 GO pulses, then oDONE with oFAIL=1.
//  4. NACK once then ACK: 2 GO pulses, oFAIL=0, oI2C_DATA stable across the retry.
//  5. END never asserted, TIMEOUT_CYC=100: GO drops after 100 cycles in WAIT_END;
//     oDONE+oFAIL pulse.
//  6. iRST_N low during WAIT_END: GO, oGRANT, oBUSY low same cycle; after release, IDLE
//     re-arbitrates from rr_ptr=0.

Source files
------------

// File: rtl/i2c_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cmd_arbiter_if
//  Purpose  : Bundles the requester handshake and the I2C_Controller
//             GO/DATA/END/ACK signals seen by i2c_cmd_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface i2c_cmd_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    iREQ;       // per-requester request level
  logic [24*NUM_REQ-1:0] iREQ_DATA;  // {slave_addr,sub_addr,data} per requester
  logic [NUM_REQ-1:0]    oGRANT;     // one-hot owner of current transaction
  logic [NUM_REQ-1:0]    oDONE;      // 1-cycle completion pulse to owner
  logic                  oFAIL;      // qualifies oDONE: command failed
  logic                  oBUSY;      // arbiter not idle
  logic [23:0]           oI2C_DATA;  // to controller I2C_DATA
  logic                  oI2C_GO;    // to controller GO
  logic                  iI2C_END;   // from controller END (async to iCLK)
  logic                  iI2C_ACK;   // from controller ACK, 1 = NACK

  // Arbiter side
  modport master (
    input  iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
    output oGRANT, oDONE, oFAIL, oBUSY, oI2C_DATA, oI2C_GO
  );

  // Requesters and controller side
  modport slave (
    output iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
    input  oGRANT, oDONE, oFAIL, oBUSY, oI2C_DATA, oI2C_GO
  );
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cmd_arbiter
//  Purpose  : Round-robin arbiter sharing one I2C_Controller between several
//             command sources. Launches GO, retries on NACK, aborts on
//             timeout and returns a done/fail pulse to the owner.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_cmd_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  wire logic           iCLK,
  input  wire logic           iRST_N,
  i2c_cmd_arbiter_if.master   bus
);

  localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT_END = 3'd2,
    S_RETRY    = 3'd3,
    S_FINISH   = 3'd4,
    S_DRAIN    = 3'd5
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     own_idx_q;
  logic [RETRY_W-1:0]   retry_cnt_q;
  logic [15:0]          tmo_cnt_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 fail_q;
  logic [23:0]          data_q;
  logic                 go_q;
  logic                 end_meta_q, end_s_q;
  logic                 ack_meta_q, ack_s_q;

  logic                 pick_found_d;
  logic [IDX_W-1:0]     pick_idx_d;

  // Index of requester k positions after the round-robin pointer
  function automatic int rr_index(input logic [IDX_W-1:0] ptr, input int k);
    return (int'(ptr) + k) % NUM_REQ;
  endfunction

  // Bring the slow-clock controller END/ACK into the iCLK domain
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      end_meta_q <= 1'b0;
      end_s_q    <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      end_meta_q <= bus.iI2C_END;
      end_s_q    <= end_meta_q;
      ack_meta_q <= bus.iI2C_ACK;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Pick the first requesting source at or after the round-robin pointer;
  // scanning from the far end lets the nearest one overwrite the others.
  always_comb begin
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.iREQ[rr_index(rr_ptr_q, k)]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = IDX_W'(rr_index(rr_ptr_q, k));
      end
    end
  end

  // Transaction sequencer: grant, launch, retry/timeout, report, drain
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      own_idx_q   <= '0;
      retry_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      fail_q      <= 1'b0;
      data_q      <= '0;
      go_q        <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses
      done_q <= '0;
      fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found_d) begin
            grant_q     <= NUM_REQ'(1) << pick_idx_d;
            own_idx_q   <= pick_idx_d;
            data_q      <= bus.iREQ_DATA[24*pick_idx_d +: 24];
            retry_cnt_q <= '0;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          go_q      <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT_END;
        end
        S_WAIT_END: begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
          if (end_s_q) begin
            go_q <= 1'b0;
            if (!ack_s_q) begin
              done_q  <= grant_q;
              state_q <= S_FINISH;
            end else if (int'(retry_cnt_q) < MAX_RETRY) begin
              retry_cnt_q <= retry_cnt_q + 1'b1;
              state_q     <= S_RETRY;
            end else begin
              done_q  <= grant_q;
              fail_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          end else if (tmo_cnt_q == TMO_LIM) begin
            go_q    <= 1'b0;
            done_q  <= grant_q;
            fail_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
        S_RETRY: begin
          // Relaunch only once the controller has released END
          if (!end_s_q) state_q <= S_LAUNCH;
        end
        S_FINISH: begin
          grant_q <= '0;
          if (int'(own_idx_q) >= NUM_REQ - 1) rr_ptr_q <= '0;
          else                                rr_ptr_q <= own_idx_q + 1'b1;
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!end_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.oGRANT    = grant_q;
  assign bus.oDONE     = done_q;
  assign bus.oFAIL     = fail_q;
  assign bus.oBUSY     = (state_q != S_IDLE);
  assign bus.oI2C_DATA = data_q;
  assign bus.oI2C_GO   = go_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_cmd_arbiter
//  Purpose  : Directed self-checking bench for i2c_cmd_arbiter with a small
//             behavioural I2C_Controller (END/ACK responder).
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_cmd_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  i2c_cmd_arbiter_if #(.NUM_REQ(3)) bus ();

  i2c_cmd_arbiter #(
    .NUM_REQ    (3),
    .MAX_RETRY  (3),
    .TIMEOUT_CYC(100)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Controller model: END+ACK rise 5 cycles into GO, END falls 3 cycles after GO drops
  int   ctl_mode  = 0;   // 0 ack, 1 always NACK, 2 NACK first launch only
  bit   no_end    = 1'b0;
  int   nack_base = 0;
  int   go_rises  = 0;
  int   viol      = 0;
  int   hi_cnt    = 0;
  int   lo_cnt    = 0;
  logic go_d      = 1'b0;
  logic nack_now;

  assign nack_now = (ctl_mode == 1) || (ctl_mode == 2 && go_rises == nack_base + 1);

  always @(posedge clk) begin
    go_d <= bus.oI2C_GO;
    if (bus.oI2C_GO && !go_d) begin
      go_rises <= go_rises + 1;
      if (bus.iI2C_END) viol <= viol + 1;
    end
    if (!rst_n) begin
      bus.iI2C_END <= 1'b0;
      bus.iI2C_ACK <= 1'b0;
      hi_cnt <= 0;
      lo_cnt <= 0;
    end else if (bus.oI2C_GO) begin
      lo_cnt <= 0;
      if (hi_cnt < 100000) hi_cnt <= hi_cnt + 1;
      if (hi_cnt == 4 && !no_end) begin
        bus.iI2C_END <= 1'b1;
        bus.iI2C_ACK <= nack_now;
      end
    end else begin
      hi_cnt <= 0;
      if (bus.iI2C_END) begin
        lo_cnt <= lo_cnt + 1;
        if (lo_cnt == 2) begin
          bus.iI2C_END <= 1'b0;
          bus.iI2C_ACK <= 1'b0;
          lo_cnt <= 0;
        end
      end
    end
  end

  // Wait (bounded) for a done pulse; reports GO-high cycles and data stability
  task automatic wait_done(output logic [2:0] d, output logic f, output bit got,
                           output int go_hi, output bit stable);
    logic [23:0] d0;
    d = '0; f = 1'b0; got = 1'b0; go_hi = 0; stable = 1'b1;
    d0 = bus.oI2C_DATA;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.oI2C_GO) go_hi++;
      if (bus.oI2C_DATA !== d0) stable = 1'b0;
      if (bus.oDONE != 3'b000) begin
        d = bus.oDONE; f = bus.oFAIL; got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.oBUSY) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.iREQ = '0;
    bus.iREQ_DATA = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.oGRANT !== 3'b000) begin bad++; $display("FAIL reset_grant: got %b want 000", bus.oGRANT); end
    total++; if (bus.oDONE  !== 3'b000) begin bad++; $display("FAIL reset_done: got %b want 000", bus.oDONE); end
    total++; if ({bus.oFAIL, bus.oBUSY, bus.oI2C_GO} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.oFAIL, bus.oBUSY, bus.oI2C_GO}); end
    total++; if (bus.oI2C_DATA !== 24'h0) begin bad++; $display("FAIL reset_data: got %h want 000000", bus.oI2C_DATA); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [2:0] d; logic f; bit got, st, ok; int gh;
    ctl_mode = 0;
    bus.iREQ_DATA = {24'h0, 24'h0, 24'h341201};
    bus.iREQ = 3'b001;
    @(negedge clk);
    total++; if (bus.oGRANT !== 3'b001) begin bad++; $display("FAIL single_grant: got %b want 001", bus.oGRANT); end
    total++; if (bus.oI2C_DATA !== 24'h341201) begin bad++; $display("FAIL single_data: got %h want 341201", bus.oI2C_DATA); end
    total++; if (bus.oI2C_GO !== 1'b0) begin bad++; $display("FAIL single_go_early: got %b want 0", bus.oI2C_GO); end
    @(negedge clk);
    total++; if (bus.oI2C_GO !== 1'b1) begin bad++; $display("FAIL single_go_latency: got %b want 1", bus.oI2C_GO); end
    wait_done(d, f, got, gh, st);
    bus.iREQ = 3'b000;
    total++; if (!got || d !== 3'b001 || f !== 1'b0) begin bad++; $display("FAIL single_done: got done=%b fail=%b seen=%0d want 001/0/1", d, f, got); end
    @(negedge clk);
    total++; if (bus.oDONE !== 3'b000) begin bad++; $display("FAIL single_done_width: got %b want 000", bus.oDONE); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_idle: got busy want idle"); end
    // rr_ptr now 1: requester 1 must beat requester 0
    bus.iREQ_DATA = {24'h0, 24'h5A0102, 24'hAAAAAA};
    bus.iREQ = 3'b011;
    @(negedge clk);
    total++; if (bus.oGRANT !== 3'b010 || bus.oI2C_DATA !== 24'h5A0102) begin bad++; $display("FAIL rr_after_single: got %b/%h want 010/5a0102", bus.oGRANT, bus.oI2C_DATA); end
    wait_done(d, f, got, gh, st);
    bus.iREQ = 3'b000;
    total++; if (d !== 3'b010) begin bad++; $display("FAIL rr_after_single_done: got %b want 010", d); end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back;
    logic [2:0] d; logic f; bit got, st, ok; int gh;
    logic [2:0]  exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [23:0] exp_d [4] = '{24'h341201, 24'h4A0203, 24'hC0FFEE, 24'h341201};
    rst_n = 1'b0;
    bus.iREQ_DATA = {24'hC0FFEE, 24'h4A0203, 24'h341201};
    bus.iREQ = 3'b111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(d, f, got, gh, st);
      if (i == 3) bus.iREQ = 3'b000;
      total++; if (d !== exp_g[i] || f !== 1'b0) begin bad++; $display("FAIL b2b_order[%0d]: got %b fail=%b want %b", i, d, f, exp_g[i]); end
      total++; if (bus.oI2C_DATA !== exp_d[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.oI2C_DATA, exp_d[i]); end
    end
    wait_idle(ok);
    total++; if (viol !== 0) begin bad++; $display("FAIL go_while_end: got %0d want 0", viol); end
  endtask

  task automatic test_nack_exhaust;
    logic [2:0] d; logic f; bit got, st, ok; int gh;
    ctl_mode = 1;
    nack_base = go_rises;
    bus.iREQ_DATA = {24'h9A0B0C, 24'h0, 24'h0};
    bus.iREQ = 3'b100;
    @(negedge clk);
    total++; if (bus.oGRANT !== 3'b100) begin bad++; $display("FAIL nack_grant: got %b want 100", bus.oGRANT); end
    wait_done(d, f, got, gh, st);
    bus.iREQ = 3'b000;
    total++; if (d !== 3'b100 || f !== 1'b1) begin bad++; $display("FAIL nack_done: got %b fail=%b want 100/1", d, f); end
    total++; if (go_rises - nack_base !== 4) begin bad++; $display("FAIL nack_go_pulses: got %0d want 4", go_rises - nack_base); end
    wait_idle(ok);
    ctl_mode = 0;
  endtask

  task automatic test_nack_once;
    logic [2:0] d; logic f; bit got, st, ok; int gh;
    ctl_mode = 2;
    nack_base = go_rises;
    bus.iREQ_DATA = {24'h0, 24'h0, 24'h123456};
    bus.iREQ = 3'b001;
    @(negedge clk);
    wait_done(d, f, got, gh, st);
    bus.iREQ = 3'b000;
    total++; if (d !== 3'b001 || f !== 1'b0) begin bad++; $display("FAIL retry_done: got %b fail=%b want 001/0", d, f); end
    total++; if (go_rises - nack_base !== 2) begin bad++; $display("FAIL retry_go_pulses: got %0d want 2", go_rises - nack_base); end
    total++; if (!st || bus.oI2C_DATA !== 24'h123456) begin bad++; $display("FAIL retry_data_stable: got %h stable=%0d want 123456/1", bus.oI2C_DATA, st); end
    wait_idle(ok);
    ctl_mode = 0;
  endtask

  task automatic test_timeout;
    logic [2:0] d; logic f; bit got, st, ok; int gh;
    no_end = 1'b1;
    bus.iREQ_DATA = {24'h0, 24'h777777, 24'h0};
    bus.iREQ = 3'b010;
    @(negedge clk);
    wait_done(d, f, got, gh, st);
    bus.iREQ = 3'b000;
    total++; if (d !== 3'b010 || f !== 1'b1) begin bad++; $display("FAIL timeout_done: got %b fail=%b want 010/1", d, f); end
    total++; if (gh < 100 || gh > 101) begin bad++; $display("FAIL timeout_go_cycles: got %0d want 100..101", gh); end
    total++; if (bus.oI2C_GO !== 1'b0) begin bad++; $display("FAIL timeout_go_low: got %b want 0", bus.oI2C_GO); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_idle: got busy want idle"); end
    no_end = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [2:0] d; logic f; bit got, st, ok; int gh;
    no_end = 1'b1;
    bus.iREQ_DATA = {24'hC0FFEE, 24'h4A0203, 24'h341201};
    bus.iREQ = 3'b010;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.oI2C_GO) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL midrst_go_start: got 0 want 1"); end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.oI2C_GO, bus.oBUSY} !== 2'b00 || bus.oGRANT !== 3'b000) begin bad++; $display("FAIL midrst_outputs: got go/busy=%b grant=%b want 00/000", {bus.oI2C_GO, bus.oBUSY}, bus.oGRANT); end
    bus.iREQ = 3'b111;
    no_end = 1'b0;
    @(negedge clk);
    total++; if (bus.oDONE !== 3'b000) begin bad++; $display("FAIL midrst_no_done: got %b want 000", bus.oDONE); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.oGRANT !== 3'b001) begin bad++; $display("FAIL midrst_rr_restart: got %b want 001", bus.oGRANT); end
    wait_done(d, f, got, gh, st);
    bus.iREQ = 3'b000;
    total++; if (d !== 3'b001 || f !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b fail=%b want 001/0", d, f); end
    wait_idle(ok);
  endtask

  initial begin
    bus.iREQ = '0;
    bus.iREQ_DATA = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_nack_exhaust();
    test_nack_once();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
